// File: rtl/rs232_receiver.sv
// rs232_receiver
//   UART receiver for LSB-first 8N1 frames (8E1 when RS232_RX_PARITY_EN is
//   defined). The line is double-flopped, the start bit is re-checked at its
//   midpoint, and every following bit is sampled one bit period later.
//   A one-byte holding register with a valid/ready handshake presents the
//   received data.
//
//   Configuration macro: RS232_RX_PARITY_EN
//     defined   -> PARITY state and even-parity check present (11-bit frame)
//     undefined -> no parity bit (10-bit frame), parity_err tied 0
//
//   Ports
//     clk         in   clock, all state updates on posedge
//     rst_n       in   synchronous active-low reset
//     rx          in   asynchronous serial line, idles high
//     data        out  [7:0] received byte, stable while data_valid is high
//     data_valid  out  holding register contains an unconsumed byte
//     data_ready  in   consumer accepts the byte when data_valid is also high
//     busy        out  receiver is anywhere but IDLE
//     frame_err   out  one-cycle pulse: stop bit sampled low
//     overrun     out  one-cycle pulse: finished byte dropped, register full
//     parity_err  out  one-cycle pulse: parity mismatch with a good stop bit
module rs232_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef RS232_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    logic          rx_meta_q, rx_s_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          done_q, done_d;         // good frame finished, hand to holding reg
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
`ifdef RS232_RX_PARITY_EN
    logic          par_bad_q, par_bad_d;   // parity result carried into STOP
    logic          parity_err_q, parity_err_d;
`endif

    // Receive FSM and bit timing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;
`ifdef RS232_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    // A high line at mid start bit is a glitch, not a frame.
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
`ifdef RS232_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef RS232_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d     = '0;
                    // Even parity: the parity bit equals the XOR of the data bits.
                    par_bad_d = rx_s_q ^ (^shift_q);
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
`ifdef RS232_RX_PARITY_EN
                        if (par_bad_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
`else
                        done_d = 1'b1;
`endif
                    end else begin
                        // Low stop bit: report once, then wait out a break.
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Holding register: a completed byte and a transfer in the same cycle
    // refill the register without dropping anything.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (done_q) begin
            if (!valid_q || data_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
`ifdef RS232_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef RS232_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rs232_receiver.sv
module tb_rs232_receiver;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int tests = 0;
    int fails = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int dv_rise = 0;
    logic dv_prev = 1'b0;
    logic [7:0] exp_q[$];

    rs232_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Monitor: counts pulses and pops the scoreboard on every transfer.
    always @(negedge clk) begin
        if (frame_err)  fe_cnt++;
        if (overrun)    ov_cnt++;
        if (parity_err) pe_cnt++;
        if (data_valid && !dv_prev) dv_rise++;
        dv_prev = data_valid;
        if (rst_n && data_valid && data_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got data=%02h, required no transfer", data);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                if (data !== e) begin
                    fails++;
                    $display("FAIL sb_data: got %02h, required %02h", data, e);
                end else begin
                    $display("[TB] transfer data=%02h ok", data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    // Start, 8 data bits LSB first, optional parity, stop. Line left at stop_bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef RS232_RX_PARITY_EN
        send_bit(par_bit);
`else
        if (par_bit) rx = 1'b1;  // no parity slot in this build
`endif
        send_bit(stop_bit);
    endtask

    // Waits for busy to rise and then fall; returns at posedge+1 of the fall.
    task automatic wait_busy_fall(output bit ok);
        int n = 0;
        while (!busy && n < 400) begin tick(1); n++; end
        while (busy && n < 400) begin tick(1); n++; end
        ok = (n < 400);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(3);
        tests++;
        if ({data, data_valid, busy, frame_err, overrun, parity_err} !== 13'h0) begin
            fails++;
            $display("FAIL reset_outputs: got data=%02h dv=%b busy=%b fe=%b ov=%b pe=%b, required all 0",
                     data, data_valid, busy, frame_err, overrun, parity_err);
        end
        rst_n = 1'b1;
        tick(2);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got busy=%b, required 0", busy);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic;
        logic [7:0] pats [4] = '{8'hA5, 8'h00, 8'hFF, 8'h80};
        data_ready = 1'b1;
        foreach (pats[k]) begin
            automatic int dv0 = dv_rise;
            automatic int err0 = fe_cnt + ov_cnt + pe_cnt;
            automatic logic [7:0] p = pats[k];
            exp_q.push_back(p);
            fork
                send_frame(p, 1'b1, ^p);
                begin
                    bit ok;
                    wait_busy_fall(ok);
                    tests++;
                    if (!ok) begin
                        fails++;
                        $display("FAIL basic_timeout: busy never completed a frame for %02h", p);
                    end
                    tests++;
                    if (data_valid !== 1'b0) begin
                        fails++;
                        $display("FAIL basic_early: got data_valid=%b at stop sample, required 0", data_valid);
                    end
                    tick(1);
                    tests++;
                    if (data_valid !== 1'b1 || data !== p) begin
                        fails++;
                        $display("FAIL basic_latency: got dv=%b data=%02h, required dv=1 data=%02h",
                                 data_valid, data, p);
                    end
                end
            join
            tests++;
            if (dv_rise - dv0 != 1 || data_valid !== 1'b0) begin
                fails++;
                $display("FAIL basic_valid: got %0d rises dv=%b, required 1 rise dv=0",
                         dv_rise - dv0, data_valid);
            end
            tests++;
            if (fe_cnt + ov_cnt + pe_cnt != err0) begin
                fails++;
                $display("FAIL basic_flags: got %0d error pulses, required 0", fe_cnt + ov_cnt + pe_cnt - err0);
            end
            $display("[TB] test_basic frame %02h sent", p);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL basic_sb_empty: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_false_start;
        int dv0 = dv_rise;
        int err0 = fe_cnt + ov_cnt + pe_cnt;
        rx = 1'b0;
        tick(4);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL false_start_busy: got busy=%b after low edge, required 1", busy);
        end
        rx = 1'b1;
        tick(24);
        tests++;
        if (busy !== 1'b0 || dv_rise != dv0 || fe_cnt + ov_cnt + pe_cnt != err0) begin
            fails++;
            $display("FAIL false_start: got busy=%b dv_rises=%0d flags=%0d, required 0/0/0",
                     busy, dv_rise - dv0, fe_cnt + ov_cnt + pe_cnt - err0);
        end
        $display("[TB] test_false_start done");
    endtask

    task automatic test_frame_err;
        int dv0 = dv_rise;
        int fe0 = fe_cnt;
        data_ready = 1'b1;
        send_frame(8'h3C, 1'b0, ^8'h3C);
        tick(40);
        tests++;
        if (fe_cnt - fe0 != 1) begin
            fails++;
            $display("FAIL frame_err_count: got %0d pulse cycles, required 1", fe_cnt - fe0);
        end
        tests++;
        if (busy !== 1'b1 || dv_rise != dv0) begin
            fails++;
            $display("FAIL frame_err_hold: got busy=%b dv_rises=%0d, required busy=1 rises=0",
                     busy, dv_rise - dv0);
        end
        rx = 1'b1;
        tick(5);
        tests++;
        if (busy !== 1'b0 || fe_cnt - fe0 != 1) begin
            fails++;
            $display("FAIL frame_err_release: got busy=%b pulses=%0d, required busy=0 pulses=1",
                     busy, fe_cnt - fe0);
        end
        $display("[TB] test_frame_err done");
    endtask

    task automatic test_overrun;
        int ov0 = ov_cnt;
        data_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, ^8'h11);
        tick(4);
        tests++;
        if (data_valid !== 1'b1 || data !== 8'h11) begin
            fails++;
            $display("FAIL overrun_first: got dv=%b data=%02h, required dv=1 data=11", data_valid, data);
        end
        send_frame(8'h22, 1'b1, ^8'h22);
        tick(4);
        tests++;
        if (data !== 8'h11 || data_valid !== 1'b1 || ov_cnt - ov0 != 1) begin
            fails++;
            $display("FAIL overrun_drop: got data=%02h dv=%b overruns=%0d, required 11/1/1",
                     data, data_valid, ov_cnt - ov0);
        end
        exp_q.push_back(8'h33);
        fork
            send_frame(8'h33, 1'b1, ^8'h33);
            begin
                bit ok;
                wait_busy_fall(ok);
                tests++;
                if (!ok) begin
                    fails++;
                    $display("FAIL overrun_timeout: frame 33 never completed");
                end
                data_ready = 1'b1;
                tick(1);
                tests++;
                if (data !== 8'h33 || data_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL overrun_simul: got data=%02h dv=%b, required 33/1", data, data_valid);
                end
            end
        join
        tests++;
        if (ov_cnt - ov0 != 1 || exp_q.size() != 0 || data_valid !== 1'b0) begin
            fails++;
            $display("FAIL overrun_final: got overruns=%0d pending=%0d dv=%b, required 1/0/0",
                     ov_cnt - ov0, exp_q.size(), data_valid);
        end
        $display("[TB] test_overrun done");
    endtask

    task automatic test_reset_mid;
        int dv0;
        data_ready = 1'b1;
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(4 * CPB + 6);
        rst_n = 1'b0;
        tick(1);
        tests++;
        if ({data, data_valid, busy, frame_err, overrun, parity_err} !== 13'h0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got data=%02h dv=%b busy=%b fe=%b ov=%b pe=%b, required all 0",
                     data, data_valid, busy, frame_err, overrun, parity_err);
        end
        tick(2);
        rst_n = 1'b1;
        tick(3);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_idle: got busy=%b, required 0", busy);
        end
        dv0 = dv_rise;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        tick(4);
        tests++;
        if (dv_rise - dv0 != 1 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL reset_mid_next: got rises=%0d pending=%0d, required 1/0", dv_rise - dv0, exp_q.size());
        end
        $display("[TB] test_reset_mid done");
    endtask

`ifdef RS232_RX_PARITY_EN
    task automatic test_parity;
        int dv0 = dv_rise;
        int pe0 = pe_cnt;
        data_ready = 1'b1;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        tick(4);
        tests++;
        if (pe_cnt != pe0 || dv_rise - dv0 != 1 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL parity_good: got pe=%0d rises=%0d pending=%0d, required 0/1/0",
                     pe_cnt - pe0, dv_rise - dv0, exp_q.size());
        end
        send_frame(8'h07, 1'b1, 1'b0);
        tick(4);
        tests++;
        if (pe_cnt - pe0 != 1 || dv_rise - dv0 != 1) begin
            fails++;
            $display("FAIL parity_bad: got pe=%0d rises=%0d, required 1/1", pe_cnt - pe0, dv_rise - dv0);
        end
        $display("[TB] test_parity done");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_mid();
`ifdef RS232_RX_PARITY_EN
        test_parity();
`endif
        tick(5);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rs232_receiver.md
RS232_RECEIVER -- requirements
Module: rs232_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 4..1024.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 rx  input  1  asynchronous serial line; idles high; LSB-first 8N1 framing (8E1 with parity option).
REQ-005 data  output  8  received byte; stable while data_valid is high.
REQ-006 data_valid  output  1  holding register contains an unconsumed byte.
REQ-007 data_ready  input  1  consumer accepts the byte; transfer occurs when data_valid and data_ready are both high on a posedge.
REQ-008 busy  output  1  high in any state except IDLE.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full.
REQ-011 parity_err  output  1  one-cycle pulse: parity mismatch; tied 0 when the parity option is compiled out.

Function
REQ-012 rx shall pass through a 2-flop synchronizer, giving rx_s; all decisions use rx_s only.
REQ-013 The FSM shall have states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE, and one bit-timing counter of width clog2(CLKS_PER_BIT).
REQ-014 IDLE: when rx_s==0, go to START with counter cleared.
REQ-015 START: at counter==CLKS_PER_BIT/2-1, sample rx_s; 0 -> DATA with counter cleared and bit index 0; 1 -> IDLE (false start, no flags).
REQ-016 DATA: at every counter==CLKS_PER_BIT-1, sample rx_s into shift bit [index]; after index 7 go to PARITY if enabled, otherwise STOP.
REQ-017 PARITY: after CLKS_PER_BIT cycles, sample the parity bit and compare with even parity over the 8 data bits.
REQ-018 STOP: after CLKS_PER_BIT cycles, sample rx_s; 1 -> frame complete, go to IDLE; 0 -> pulse frame_err, discard the byte, go to WAIT_IDLE.
REQ-019 WAIT_IDLE: stay until rx_s==1, then go to IDLE (break handling; no repeated frame_err).
REQ-020 Parity mismatch with a good stop bit: pulse parity_err in the stop-sample cycle and discard the byte.
REQ-021 Good frame: data/data_valid shall update on the posedge after the stop sample (1-cycle latency).
REQ-022 A good frame arriving with data_valid=1 and data_ready=0 shall leave data unchanged and pulse overrun.
REQ-023 Simultaneous completion and transfer (data_valid=1, data_ready=1): load the new byte, keep data_valid=1, no overrun.
REQ-024 data_valid shall fall on the posedge after a transfer unless REQ-023 applies.
REQ-025 Sampling shall proceed regardless of data_ready; the receiver never stalls the line.

Reset
REQ-026 With rst_n low on a posedge: FSM=IDLE, counter=0, index=0, data=8'h00, data_valid=0, busy=0, all error pulses 0, synchronizer flops=1.
REQ-027 Reset mid-frame shall abandon the frame with no flags; after release the line is treated as idle, and a low rx_s starts a new frame per REQ-014.

Configuration
REQ-028 Macro RS232_RX_PARITY_EN: when defined, the PARITY state and even-parity check are present (11-bit frame); when undefined, PARITY is absent, DATA goes directly to STOP (10-bit frame), and parity_err is constant 0.

Verification (CLKS_PER_BIT=16, parity off unless noted)
REQ-029 Send 0xA5, data_ready=1 -> data=0xA5, data_valid high 1 cycle after the stop sample, no error flags.
REQ-030 rx low pulse of 4 cycles, then high -> FSM returns to IDLE, busy falls, no data_valid, no flags.
REQ-031 Send 0x3C with a low stop bit, rx held low 40 cycles -> exactly one frame_err pulse, no data_valid, busy until rx high.
REQ-032 Send 0x11, hold data_ready=0, send 0x22 -> data stays 0x11, one overrun pulse; then data_ready=1 and send 0x33 in the same cycle -> data=0x33, no overrun.
REQ-033 rst_n low during bit 4 of 0xFF -> all outputs at reset values; next frame 0x5A is received correctly.
REQ-034 RS232_RX_PARITY_EN defined: 0x07 with parity 1 -> accepted; 0x07 with parity 0 -> parity_err pulse, no data_valid.
